// File: rtl/mul_rr_sequencer.sv
// Round-robin sequencer sharing one repeated-addition multiplier datapath between two requesters.
// Optional build macro MUL_OPSWAP_EN: swap operands at acceptance so the smaller one is the loop count.
module mul_rr_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rsp_valid0,
    output logic         rsp_valid1,
    output logic [W-1:0] rsp_data,
    output logic         busy,
    output logic         lda,
    output logic         ldb,
    output logic         ldp,
    output logic         clrp,
    output logic         decb,
    output logic [W-1:0] data_in,
    input  logic         eqz,
    input  logic [W-1:0] prod
);

    typedef enum logic [2:0] {
        S_IDLE, S_LA, S_LB, S_CHK, S_ADD, S_DONE
    } state_t;

    state_t       r_state, w_state_nxt;
    logic         r_last;
    logic         r_cur;
    logic [W-1:0] r_opa;
    logic [W-1:0] r_opb;
    logic [W-1:0] r_rsp_data;

    logic         w_any_req;
    logic         w_win;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_opa_nxt;
    logic [W-1:0] w_opb_nxt;

    // On a tie the requester that was not served last wins; a lone requester always wins.
    assign w_any_req = req0 | req1;
    assign w_win     = (req0 & req1) ? ~r_last : req1;
    assign w_a       = w_win ? a1 : a0;
    assign w_b       = w_win ? b1 : b0;

`ifdef MUL_OPSWAP_EN
    assign w_opa_nxt = (w_a < w_b) ? w_b : w_a;
    assign w_opb_nxt = (w_a < w_b) ? w_a : w_b;
`else
    assign w_opa_nxt = w_a;
    assign w_opb_nxt = w_b;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= 1'b1;
            r_cur      <= 1'b0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_rsp_data <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_cur  <= w_win;
                r_last <= w_win;
                r_opa  <= w_opa_nxt;
                r_opb  <= w_opb_nxt;
            end
            if (r_state == S_CHK && eqz) begin
                r_rsp_data <= prod;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_LA;
            S_LA:    w_state_nxt = S_LB;
            S_LB:    w_state_nxt = S_CHK;
            S_CHK:   w_state_nxt = eqz ? S_DONE : S_ADD;
            S_ADD:   w_state_nxt = S_CHK;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        rsp_valid0 = 1'b0;
        rsp_valid1 = 1'b0;
        lda        = 1'b0;
        ldb        = 1'b0;
        ldp        = 1'b0;
        clrp       = 1'b0;
        decb       = 1'b0;
        data_in    = '0;
        busy       = (r_state != S_IDLE);
        unique case (r_state)
            S_LA: begin
                gnt0    = ~r_cur;
                gnt1    = r_cur;
                lda     = 1'b1;
                data_in = r_opa;
            end
            S_LB: begin
                ldb     = 1'b1;
                clrp    = 1'b1;
                data_in = r_opb;
            end
            S_ADD: begin
                ldp  = 1'b1;
                decb = 1'b1;
            end
            S_DONE: begin
                rsp_valid0 = ~r_cur;
                rsp_valid1 = r_cur;
            end
            default: ;
        endcase
    end

    assign rsp_data = r_rsp_data;

endmodule
